// File: rtl/alignment_word_assembler.sv
// rtl/alignment_word_assembler.sv - reassembles 7-byte lane frames from the alignment FIFO into 32-bit words
// Optional pad-byte checking is built when PAD_CHECK_EN is defined.
module alignment_word_assembler #(
  parameter int W         = 32,
  parameter int FRAME_LEN = 7
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [7:0]   fifo_dout,
  input  logic         fifo_empty,
  output logic         fifo_re,
  output logic [W-1:0] word,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         pad_err
);

  localparam logic [2:0] ISSUE_MAX = 3'(FRAME_LEN);
  localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [2:0]   issue_cnt;
  logic [2:0]   cap_idx;
  logic         rd_pend;
  logic [W-1:0] word_q;
  logic         word_valid_q;
  logic         rd_accept;
  logic         cap_last;
  logic         handshake;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Read enable is gated by resetn so no byte is pulled from the FIFO while held in reset.
  always_comb begin
    state_nxt = state;
    rd_accept = 1'b0;
    cap_last  = 1'b0;
    handshake = 1'b0;
    case (state)
      COLLECT: begin
        rd_accept = resetn & ~fifo_empty & (issue_cnt < ISSUE_MAX);
        cap_last  = rd_pend & (cap_idx == LAST_IDX);
        if (cap_last) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        handshake = word_valid_q & word_ready;
        if (handshake) begin
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  assign fifo_re = rd_accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issue_cnt    <= 3'd0;
      cap_idx      <= 3'd0;
      rd_pend      <= 1'b0;
      word_valid_q <= 1'b0;
    end else begin
      rd_pend <= rd_accept;
      if (handshake) begin
        issue_cnt <= 3'd0;
        cap_idx   <= 3'd0;
      end else begin
        if (rd_accept) begin
          issue_cnt <= issue_cnt + 3'd1;
        end
        if (rd_pend && (cap_idx != LAST_IDX)) begin
          cap_idx <= cap_idx + 3'd1;
        end
      end
      if (cap_last) begin
        word_valid_q <= 1'b1;
      end else if (handshake) begin
        word_valid_q <= 1'b0;
      end
    end
  end

  // Payload bytes land little-endian; pad bytes never touch the word register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_q <= '0;
    end else if (rd_pend && (state == COLLECT)) begin
      case (cap_idx)
        3'd0:    word_q[7:0]   <= fifo_dout;
        3'd1:    word_q[15:8]  <= fifo_dout;
        3'd2:    word_q[23:16] <= fifo_dout;
        3'd3:    word_q[31:24] <= fifo_dout;
        default: word_q        <= word_q;
      endcase
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;

`ifdef PAD_CHECK_EN
  logic pad_err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pad_err_q <= 1'b0;
    end else if (rd_pend && (cap_idx >= 3'd4) && (fifo_dout != 8'h00)) begin
      pad_err_q <= 1'b1;
    end
  end

  assign pad_err = pad_err_q;
`else
  assign pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_alignment_word_assembler.sv
// tb/tb_alignment_word_assembler.sv - directed self-checking bench for alignment_word_assembler
// Build with PAD_CHECK_EN defined to expect the sticky pad error.
module tb_alignment_word_assembler;

`ifdef PAD_CHECK_EN
  localparam logic EXP_PAD = 1'b1;
`else
  localparam logic EXP_PAD = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_re;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        pad_err;

  logic [7:0]  mem [0:255];
  logic [7:0]  wr_ptr;
  logic [7:0]  rd_ptr;
  logic        gap;
  logic        flush;

  logic        re_log   [0:31];
  logic        vld_log  [0:31];
  logic        perr_log [0:31];
  logic [31:0] word_log [0:31];

  int checks;
  int failures;

  alignment_word_assembler #(.W(32), .FRAME_LEN(7)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .pad_err    (pad_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after an accepted read.
  assign fifo_empty = gap | (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_re && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] w, input logic [7:0] p6);
    logic [7:0] b [0:6];
    b[0] = w[7:0];
    b[1] = w[15:8];
    b[2] = w[23:16];
    b[3] = w[31:24];
    b[4] = 8'h00;
    b[5] = 8'h00;
    b[6] = p6;
    for (int i = 0; i < 7; i++) begin
      mem[wr_ptr] = b[i];
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  // Called just after a negedge; cycle 0 is the cycle in progress.
  task automatic run(input int n, input int ready_from, input int gap_start, input int gap_len);
    for (int cyc = 0; cyc < n; cyc++) begin
      gap        = (cyc >= gap_start) && (cyc < gap_start + gap_len);
      word_ready = (cyc >= ready_from);
      #1;
      re_log[cyc]   = fifo_re;
      vld_log[cyc]  = word_valid;
      perr_log[cyc] = pad_err;
      word_log[cyc] = word;
      @(negedge clk);
    end
    gap = 1'b0;
  endtask

  function automatic int count_re(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(re_log[i]);
    return c;
  endfunction

  function automatic int count_vld(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(vld_log[i]);
    return c;
  endfunction

  initial begin
    checks     = 0;
    failures   = 0;
    resetn     = 1'b0;
    word_ready = 1'b0;
    gap        = 1'b0;
    flush      = 1'b0;
    wr_ptr     = 8'd0;
    rd_ptr     = 8'd0;
    fifo_dout  = 8'h00;

    // Reset state, with a frame already waiting in the FIFO
    push_frame(32'h44332211, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    check("rst_fifo_re", 32'(fifo_re), 32'd0);
    check("rst_word", word, 32'h0);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_pad_err", 32'(pad_err), 32'd0);
    @(negedge clk);

    // Single frame, ready held high
    resetn = 1'b1;
    run(12, 0, 99, 0);
    check("single_re_count", 32'(count_re(0, 11)), 32'd7);
    check("single_re_c0_6", 32'(count_re(0, 6)), 32'd7);
    check("single_valid_c8", 32'(vld_log[8]), 32'd1);
    check("single_valid_count", 32'(count_vld(0, 11)), 32'd1);
    check("single_word", word_log[8], 32'h44332211);
    check("single_pad_err", 32'(perr_log[9]), 32'd0);

    // Backpressure: ready low for 5 cycles after valid, second frame waiting
    push_frame(32'h88776655, 8'h00);
    push_frame(32'h04030201, 8'h00);
    run(24, 13, 99, 0);
    check("bp_valid_c8_13", 32'(count_vld(8, 13)), 32'd6);
    check("bp_no_re_hold", 32'(count_re(7, 13)), 32'd0);
    for (int i = 8; i <= 13; i++) check("bp_word_stable", word_log[i], 32'h88776655);
    check("bp_valid_drop_c14", 32'(vld_log[14]), 32'd0);
    check("bp_re_c14", 32'(re_log[14]), 32'd1);
    check("bp_second_valid_c22", 32'(vld_log[22]), 32'd1);
    check("bp_second_word", word_log[22], 32'h04030201);

    // Empty gap of 3 cycles after byte 1
    push_frame(32'h44332211, 8'h00);
    run(14, 0, 2, 3);
    check("gap_no_re", 32'(count_re(2, 4)), 32'd0);
    check("gap_re_count", 32'(count_re(0, 13)), 32'd7);
    check("gap_valid_c10", 32'(vld_log[10]), 32'd0);
    check("gap_valid_c11", 32'(vld_log[11]), 32'd1);
    check("gap_word", word_log[11], 32'h44332211);

    // Back-to-back frames with ready high
    push_frame(32'hDDCCBBAA, 8'h00);
    push_frame(32'h04030201, 8'h00);
    run(20, 0, 99, 0);
    check("b2b_valid_c8", 32'(vld_log[8]), 32'd1);
    check("b2b_word0", word_log[8], 32'hDDCCBBAA);
    check("b2b_re_c9", 32'(re_log[9]), 32'd1);
    check("b2b_valid_c17", 32'(vld_log[17]), 32'd1);
    check("b2b_word1", word_log[17], 32'h04030201);
    check("b2b_valid_count", 32'(count_vld(0, 19)), 32'd2);

    // Non-zero third pad byte, then a clean frame
    push_frame(32'h44332211, 8'h5A);
    run(10, 0, 99, 0);
    check("pad_err_c7", 32'(perr_log[7]), 32'd0);
    check("pad_err_c8", 32'(perr_log[8]), 32'(EXP_PAD));
    check("pad_word", word_log[8], 32'h44332211);
    push_frame(32'hCAFEF00D, 8'h00);
    run(10, 0, 99, 0);
    check("pad_err_sticky", 32'(perr_log[9]), 32'(EXP_PAD));
    check("pad_clean_word", word_log[8], 32'hCAFEF00D);

    // Reset after two bytes read
    push_frame(32'h99887766, 8'h00);
    run(2, 0, 99, 0);
    resetn = 1'b0;
    flush  = 1'b1;
    #1;
    check("midrst_fifo_re", 32'(fifo_re), 32'd0);
    check("midrst_word", word, 32'h0);
    check("midrst_valid", 32'(word_valid), 32'd0);
    check("midrst_pad_err", 32'(pad_err), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    push_frame(32'h44332211, 8'h00);
    resetn = 1'b1;
    run(10, 0, 99, 0);
    check("midrst_valid_c8", 32'(vld_log[8]), 32'd1);
    check("midrst_word_after", word_log[8], 32'h44332211);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
